// File: rtl/ring_input_vc_buffer_if.sv
// ring_input_vc_buffer_if
//   Bundles every signal of one ring-router input port except clock and reset.
//   slave  : seen by the buffer (takes upstream flits and grants, drives ready,
//            requests, head flits, occupancy and the error flag).
//   master : seen by the surrounding router / bench (the reverse directions).
//   Signals:
//     polarity      router phase; 1 = write odd/read even, 0 = write even/read odd
//     si, ri, di    upstream send-valid, ready and flit
//     req_*_even/odd, gnt_*_even/odd   per-VC fwd/PE requests and their grants
//     dout_even/odd head flits (hop-adjusted when forwarded)
//     cnt_even/odd  per-VC occupancy
//     err           sticky protocol-error flag
interface ring_input_vc_buffer_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  polarity;
    logic                  si;
    logic                  ri;
    logic [DATA_WIDTH-1:0] di;
    logic                  req_fwd_even;
    logic                  req_pe_even;
    logic                  req_fwd_odd;
    logic                  req_pe_odd;
    logic                  gnt_fwd_even;
    logic                  gnt_pe_even;
    logic                  gnt_fwd_odd;
    logic                  gnt_pe_odd;
    logic [DATA_WIDTH-1:0] dout_even;
    logic [DATA_WIDTH-1:0] dout_odd;
    logic [CNT_W-1:0]      cnt_even;
    logic [CNT_W-1:0]      cnt_odd;
    logic                  err;

    modport slave (
        input  polarity, si, di,
        input  gnt_fwd_even, gnt_pe_even, gnt_fwd_odd, gnt_pe_odd,
        output ri,
        output req_fwd_even, req_pe_even, req_fwd_odd, req_pe_odd,
        output dout_even, dout_odd, cnt_even, cnt_odd, err
    );

    modport master (
        output polarity, si, di,
        output gnt_fwd_even, gnt_pe_even, gnt_fwd_odd, gnt_pe_odd,
        input  ri,
        input  req_fwd_even, req_pe_even, req_fwd_odd, req_pe_odd,
        input  dout_even, dout_odd, cnt_even, cnt_odd, err
    );
endinterface

// File: rtl/ring_input_vc_buffer.sv
// ring_input_vc_buffer
//   Ring-router input port with two virtual channels (even = index 0, odd = index 1),
//   each a DEPTH-flit FIFO. polarity picks the write VC (odd when 1) and the read VC
//   (even when 1), so a VC is never pushed and popped in the same cycle. The head of
//   the read VC requests the PE output when its hop field is zero, otherwise the
//   forward output with the hop field decremented on dout. Used for both cw and ccw.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset (pointers, counts, err; not the memory)
//     bus  ring_input_vc_buffer_if.slave (handshake, requests/grants, heads, status)
module ring_input_vc_buffer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned HOP_LSB    = 48,
    parameter int unsigned HOP_W      = 8
) (
    input logic                   clk,
    input logic                   rst,
    ring_input_vc_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and >= 2");
    end
    if (HOP_LSB + HOP_W > DATA_WIDTH) begin : g_bad_hop
        $error("hop field does not fit in the flit");
    end

    // Storage and state, indexed [0] = even VC, [1] = odd VC.
    logic [DATA_WIDTH-1:0] mem_q    [2][DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [2];
    logic [PTR_W-1:0]      rd_ptr_q [2];
    logic [CNT_W-1:0]      cnt_q    [2];
    logic [CNT_W-1:0]      cnt_d    [2];
    logic                  err_q;
    logic                  err_d;

    logic [1:0]            wr_sel;
    logic [1:0]            rd_sel;
    logic [1:0]            full;
    logic [1:0]            empty;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            req_fwd;
    logic [1:0]            req_pe;
    logic [1:0]            gnt_fwd;
    logic [1:0]            gnt_pe;
    logic [1:0]            bad_gnt;
    logic                  drop;
    logic [DATA_WIDTH-1:0] head     [2];
    logic [DATA_WIDTH-1:0] dout     [2];
    logic [HOP_W-1:0]      hop      [2];

    // Per-VC status, requests, head flits and pop/push decisions.
    always_comb begin
        wr_sel  = {bus.polarity, ~bus.polarity};
        rd_sel  = {~bus.polarity, bus.polarity};
        gnt_fwd = {bus.gnt_fwd_odd, bus.gnt_fwd_even};
        gnt_pe  = {bus.gnt_pe_odd, bus.gnt_pe_even};
        full    = '0;
        empty   = '0;
        push    = '0;
        pop     = '0;
        req_fwd = '0;
        req_pe  = '0;
        bad_gnt = '0;
        for (int v = 0; v < 2; v++) begin
            full[v]  = (cnt_q[v] == FULL_CNT);
            empty[v] = (cnt_q[v] == '0);
            head[v]  = mem_q[v][rd_ptr_q[v]];
            hop[v]   = head[v][HOP_LSB +: HOP_W];

            // Only the non-empty read VC may request.
            req_fwd[v] = rd_sel[v] && !empty[v] && (hop[v] != '0);
            req_pe[v]  = rd_sel[v] && !empty[v] && (hop[v] == '0);

            dout[v] = '0;
            if (!empty[v]) begin
                dout[v] = head[v];
                if (hop[v] != '0) begin
                    dout[v][HOP_LSB +: HOP_W] = hop[v] - HOP_W'(1);
                end
            end

            // A dual grant still pops once: at most one of the two can match.
            pop[v]     = (gnt_fwd[v] && req_fwd[v]) || (gnt_pe[v] && req_pe[v]);
            bad_gnt[v] = (gnt_fwd[v] && !req_fwd[v]) || (gnt_pe[v] && !req_pe[v]);
            push[v]    = bus.si && wr_sel[v] && !full[v];
        end
        drop  = bus.si && |(wr_sel & full);
        err_d = err_q || drop || (|bad_gnt);
        for (int v = 0; v < 2; v++) begin
            cnt_d[v] = cnt_q[v];
            if (push[v]) begin
                cnt_d[v] = cnt_q[v] + CNT_W'(1);
            end else if (pop[v]) begin
                cnt_d[v] = cnt_q[v] - CNT_W'(1);
            end
        end
    end

    // Flit storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int v = 0; v < 2; v++) begin
            if (push[v]) begin
                mem_q[v][wr_ptr_q[v]] <= bus.di;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < 2; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (push[v]) begin
                    wr_ptr_q[v] <= wr_ptr_q[v] + PTR_W'(1);
                end
                if (pop[v]) begin
                    rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
                end
                cnt_q[v] <= cnt_d[v];
            end
            err_q <= err_d;
        end
    end

    assign bus.ri           = ~|(wr_sel & full);
    assign bus.req_fwd_even = req_fwd[0];
    assign bus.req_pe_even  = req_pe[0];
    assign bus.req_fwd_odd  = req_fwd[1];
    assign bus.req_pe_odd   = req_pe[1];
    assign bus.dout_even    = dout[0];
    assign bus.dout_odd     = dout[1];
    assign bus.cnt_even     = cnt_q[0];
    assign bus.cnt_odd      = cnt_q[1];
    assign bus.err          = err_q;
endmodule
